// File: rtl/spi_burst_seq_if.sv
// Bundle of the command, byte-stream, SPI-controller bus and status signals
// of spi_burst_seq. slave is the sequencer side, master the environment side.
interface spi_burst_seq_if #(
  parameter int CS_LENGTH = 32,
  parameter int LEN_W     = 16
) ();

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [CS_LENGTH-1:0] cmd_sel;
  logic [LEN_W-1:0]     cmd_len;
  logic                 cmd_tx_en;
  logic                 cmd_rx_en;

  logic                 tx_valid;
  logic                 tx_ready;
  logic [7:0]           tx_data;

  logic                 rx_valid;
  logic                 rx_ready;
  logic [7:0]           rx_data;

  logic                 spi_wr;
  logic                 spi_rd;
  logic [7:0]           spi_addr;
  logic [31:0]          spi_wdat;
  logic [31:0]          spi_rdat;
  logic                 spi_done;

  logic                 busy;
  logic                 cmd_done;

  modport slave (
    input  cmd_valid, cmd_sel, cmd_len, cmd_tx_en, cmd_rx_en,
    input  tx_valid, tx_data, rx_ready, spi_rdat, spi_done,
    output cmd_ready, tx_ready, rx_valid, rx_data,
    output spi_wr, spi_rd, spi_addr, spi_wdat, busy, cmd_done
  );

  modport master (
    output cmd_valid, cmd_sel, cmd_len, cmd_tx_en, cmd_rx_en,
    output tx_valid, tx_data, rx_ready, spi_rdat, spi_done,
    input  cmd_ready, tx_ready, rx_valid, rx_data,
    input  spi_wr, spi_rd, spi_addr, spi_wdat, busy, cmd_done
  );

endinterface

// File: rtl/spi_burst_seq.sv
// Burst sequencer: selects devices, shifts a counted run of bytes through an
// SPI controller's register bus, then deselects. CS_LENGTH must be <= 32.
module spi_burst_seq #(
  parameter int CS_LENGTH = 32,
  parameter int LEN_W     = 16
) (
  input  logic           clk,
  input  logic           reset,
  spi_burst_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, CS_ON, GET_TX, XFER, READ, PUSH_RX, CS_OFF, FIN
  } state_e;

  localparam logic [7:0] ADDR_CS   = 8'h04;
  localparam logic [7:0] ADDR_DATA = 8'h08;

  state_e               state_q, state_d;
  logic [LEN_W-1:0]     count_q, count_d;
  logic [CS_LENGTH-1:0] sel_q, sel_d;
  logic                 tx_en_q, tx_en_d;
  logic                 rx_en_q, rx_en_d;
  logic [7:0]           byte_q, byte_d;
  logic [7:0]           rx_data_q, rx_data_d;
  logic                 wr_q, wr_d;
  logic                 rd_q, rd_d;
  logic [7:0]           addr_q, addr_d;
  logic [31:0]          wdat_q, wdat_d;

  logic                 req_wr, req_rd;
  logic [7:0]           req_addr;
  logic [31:0]          req_wdat;
  logic                 acc_done;
  logic [31:0]          cs_on_word, cs_off_word;
  logic [LEN_W-1:0]     count_dec;

  always_comb begin
    // NOTE: every signal gets its default first so no path can infer a latch.
    state_d   = state_q;
    count_d   = count_q;
    sel_d     = sel_q;
    tx_en_d   = tx_en_q;
    rx_en_d   = rx_en_q;
    byte_d    = byte_q;
    rx_data_d = rx_data_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    addr_d    = addr_q;
    wdat_d    = wdat_q;
    req_wr    = 1'b0;
    req_rd    = 1'b0;
    req_addr  = ADDR_CS;
    req_wdat  = '0;
    acc_done  = 1'b0;

    cs_on_word                  = '0;
    cs_on_word[CS_LENGTH-1:0]   = ~sel_q;
    cs_off_word                 = '0;
    cs_off_word[CS_LENGTH-1:0]  = '1;
    count_dec = (count_q != '0) ? count_q - LEN_W'(1) : count_q;

    case (state_q)
      CS_ON:   begin req_wr = 1'b1; req_addr = ADDR_CS;   req_wdat = cs_on_word;     end
      XFER:    begin req_wr = 1'b1; req_addr = ADDR_DATA; req_wdat = {24'h0, byte_q}; end
      READ:    begin req_rd = 1'b1; req_addr = ADDR_DATA;                            end
      CS_OFF:  begin req_wr = 1'b1; req_addr = ADDR_CS;   req_wdat = cs_off_word;    end
      default: ;
    endcase

    // A bus state first spends one cycle with the strobes low (the mandatory
    // gap), then raises its request and holds it until the controller answers.
    if (req_wr || req_rd) begin
      if (!(wr_q || rd_q)) begin
        wr_d   = req_wr;
        rd_d   = req_rd;
        addr_d = req_addr;
        wdat_d = req_wdat;
      end else if (bus.spi_done) begin
        wr_d     = 1'b0;
        rd_d     = 1'b0;
        acc_done = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          sel_d   = bus.cmd_sel;
          count_d = bus.cmd_len;
          tx_en_d = bus.cmd_tx_en;
          rx_en_d = bus.cmd_rx_en;
          state_d = CS_ON;
        end
      end
      CS_ON: begin
        if (acc_done) state_d = (count_q != '0) ? GET_TX : CS_OFF;
      end
      GET_TX: begin
        if (!tx_en_q) begin
          byte_d  = 8'hFF;
          state_d = XFER;
        end else if (bus.tx_valid) begin
          byte_d  = bus.tx_data;
          state_d = XFER;
        end
      end
      XFER: begin
        if (acc_done) begin
          if (rx_en_q) begin
            state_d = READ;
          end else begin
            count_d = count_dec;
            state_d = (count_dec != '0) ? GET_TX : CS_OFF;
          end
        end
      end
      READ: begin
        if (acc_done) begin
          rx_data_d = bus.spi_rdat[7:0];
          state_d   = PUSH_RX;
        end
      end
      PUSH_RX: begin
        if (bus.rx_ready) begin
          count_d = count_dec;
          state_d = (count_dec != '0) ? GET_TX : CS_OFF;
        end
      end
      CS_OFF: begin
        if (acc_done) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      sel_q     <= '0;
      tx_en_q   <= 1'b0;
      rx_en_q   <= 1'b0;
      byte_q    <= '0;
      rx_data_q <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      addr_q    <= '0;
      wdat_q    <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      sel_q     <= sel_d;
      tx_en_q   <= tx_en_d;
      rx_en_q   <= rx_en_d;
      byte_q    <= byte_d;
      rx_data_q <= rx_data_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      addr_q    <= addr_d;
      wdat_q    <= wdat_d;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE) && !reset;
  assign bus.tx_ready  = (state_q == GET_TX) && tx_en_q;
  assign bus.rx_valid  = (state_q == PUSH_RX);
  assign bus.rx_data   = rx_data_q;
  assign bus.spi_wr    = wr_q;
  assign bus.spi_rd    = rd_q;
  assign bus.spi_addr  = addr_q;
  assign bus.spi_wdat  = wdat_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.cmd_done  = (state_q == FIN);

endmodule

// File: tb/tb_spi_burst_seq.sv
// Randomized scoreboard bench for spi_burst_seq: an SPI-controller responder,
// tx source and rx sink each check the DUT against per-command expectations.
module tb_spi_burst_seq;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdat;
  } acc_t;

  logic clk;
  logic reset;

  spi_burst_seq_if #(.CS_LENGTH(32), .LEN_W(16)) bus_if ();

  spi_burst_seq #(.CS_LENGTH(32), .LEN_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  acc_t        exp_bus_q[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  exp_rx_q[$];
  logic [31:0] rd_data_q[$];
  logic [7:0]  force_tx[$];
  logic [7:0]  force_rd[$];

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  bit tx_allowed = 0;
  bit rx_allowed = 0;
  int rx_stall = 0;
  bit hold_xfer = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic acc_t mk_acc(input logic wr, input logic [7:0] addr,
                                  input logic [31:0] wdat);
    acc_t a;
    a.wr = wr; a.addr = addr; a.wdat = wdat;
    return a;
  endfunction

  task automatic flush_all();
    exp_bus_q.delete(); tx_q.delete(); exp_rx_q.delete();
    rd_data_q.delete(); force_tx.delete(); force_rd.delete();
    tx_allowed = 0; rx_allowed = 0; rx_stall = 0; hold_xfer = 0;
  endtask

  // SPI controller model: answers each request after 0..10 cycles, also
  // raises spurious done pulses while idle, and checks the bus protocol.
  initial begin
    bit          active;
    bit          given;
    int          delay;
    logic [41:0] held;
    logic [41:0] cur;
    acc_t        e;
    logic [31:0] junk;
    active = 0; given = 0; delay = 0; held = '0;
    bus_if.spi_done = 1'b0;
    bus_if.spi_rdat = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        active = 0; given = 0; bus_if.spi_done = 1'b0;
        continue;
      end
      cur = {bus_if.spi_wr, bus_if.spi_rd, bus_if.spi_addr, bus_if.spi_wdat};
      if (given) begin
        check(!(bus_if.spi_wr || bus_if.spi_rd), "bus_low_after_done",
              {bus_if.spi_wr, bus_if.spi_rd}, 0);
        given = 0;
      end
      if (bus_if.spi_wr || bus_if.spi_rd) begin
        if (!active) begin
          check(!(bus_if.spi_wr && bus_if.spi_rd), "wr_rd_exclusive",
                {bus_if.spi_wr, bus_if.spi_rd}, 0);
          if (exp_bus_q.size() == 0) begin
            check(0, "unexpected_access", cur, 0);
          end else begin
            e = exp_bus_q.pop_front();
            check(bus_if.spi_wr == e.wr && bus_if.spi_rd == !e.wr, "bus_op",
                  {bus_if.spi_wr, bus_if.spi_rd}, {e.wr, !e.wr});
            check(bus_if.spi_addr == e.addr, "bus_addr", bus_if.spi_addr, e.addr);
            if (e.wr) check(bus_if.spi_wdat == e.wdat, "bus_wdat", bus_if.spi_wdat, e.wdat);
          end
          held   = cur;
          active = 1;
          delay  = (hold_xfer && bus_if.spi_addr == 8'h08) ? 1000000 : int'($urandom_range(0, 10));
        end else begin
          check(cur == held, "bus_hold", cur, held);
        end
        junk = $urandom;
        if (delay == 0) begin
          bus_if.spi_done = 1'b1;
          if (bus_if.spi_rd && rd_data_q.size() != 0) bus_if.spi_rdat = rd_data_q.pop_front();
          else bus_if.spi_rdat = junk;
          active = 0;
          given  = 1;
        end else begin
          delay--;
          bus_if.spi_done = 1'b0;
          bus_if.spi_rdat = junk;
        end
      end else begin
        if (active) begin
          check(0, "bus_dropped_before_done", cur, held);
          active = 0;
        end
        bus_if.spi_done = ($urandom_range(0, 5) == 0);
        bus_if.spi_rdat = $urandom;
      end
    end
  end

  // tx source: offers queued bytes with random bubbles, junk while not ready.
  initial begin
    bit hs;
    hs = 0;
    bus_if.tx_valid = 1'b0;
    bus_if.tx_data  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hs = 0; bus_if.tx_valid = 1'b0;
        continue;
      end
      if (hs && tx_q.size() != 0) void'(tx_q.pop_front());
      if (bus_if.tx_ready) check(tx_allowed, "tx_ready_without_tx_en", bus_if.tx_ready, 0);
      if (bus_if.tx_ready && tx_q.size() != 0) begin
        bus_if.tx_valid = ($urandom_range(0, 3) != 0);
        bus_if.tx_data  = bus_if.tx_valid ? tx_q[0] : 8'($urandom);
      end else begin
        bus_if.tx_valid = 1'($urandom);
        bus_if.tx_data  = 8'($urandom);
      end
      hs = bus_if.tx_valid && bus_if.tx_ready;
    end
  end

  // rx sink: compares each presented byte, checks it stays stable while
  // stalled, and that no bus access happens while a byte waits.
  initial begin
    bit         hs;
    bit         have;
    int         wait_n;
    logic [7:0] held;
    logic [7:0] e;
    hs = 0; have = 0; wait_n = 0; held = '0;
    bus_if.rx_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hs = 0; have = 0; bus_if.rx_ready = 1'b0;
        continue;
      end
      if (hs) have = 0;
      if (bus_if.rx_valid) begin
        check(!(bus_if.spi_wr || bus_if.spi_rd), "bus_idle_in_push_rx",
              {bus_if.spi_wr, bus_if.spi_rd}, 0);
        if (!have) begin
          have   = 1;
          held   = bus_if.rx_data;
          wait_n = rx_stall;
          check(rx_allowed, "rx_valid_without_rx_en", bus_if.rx_valid, 0);
          if (exp_rx_q.size() == 0) begin
            check(0, "unexpected_rx", bus_if.rx_data, 0);
          end else begin
            e = exp_rx_q.pop_front();
            check(bus_if.rx_data == e, "rx_data", bus_if.rx_data, e);
          end
        end else begin
          check(bus_if.rx_data == held, "rx_data_stable", bus_if.rx_data, held);
        end
        if (wait_n > 0) begin
          wait_n--;
          bus_if.rx_ready = 1'b0;
        end else begin
          bus_if.rx_ready = ($urandom_range(0, 2) != 0);
        end
      end else begin
        bus_if.rx_ready = 1'($urandom);
      end
      hs = bus_if.rx_valid && bus_if.rx_ready;
    end
  end

  initial begin
    bit prev;
    prev = 0;
    forever begin
      @(negedge clk);
      if (!reset && bus_if.cmd_done) begin
        done_cnt++;
        check(!prev, "cmd_done_one_cycle", prev, 0);
      end
      prev = bus_if.cmd_done && !reset;
    end
  end

  // Reference model: the full access list, tx bytes and rx bytes of a burst.
  task automatic start_cmd(input logic [31:0] sel, input int len,
                           input bit tx_en, input bit rx_en,
                           input bit echo, input int stall);
    logic [7:0]  b;
    logic [7:0]  r;
    logic [31:0] junk;
    int          n;
    exp_bus_q.push_back(mk_acc(1'b1, 8'h04, ~sel));
    for (int i = 0; i < len; i++) begin
      if (tx_en) begin
        b = (force_tx.size() != 0) ? force_tx.pop_front() : 8'($urandom);
        tx_q.push_back(b);
      end else begin
        b = 8'hFF;
      end
      exp_bus_q.push_back(mk_acc(1'b1, 8'h08, {24'h0, b}));
      if (rx_en) begin
        r    = echo ? b : ((force_rd.size() != 0) ? force_rd.pop_front() : 8'($urandom));
        junk = $urandom;
        rd_data_q.push_back({junk[31:8], r});
        exp_bus_q.push_back(mk_acc(1'b0, 8'h08, 32'h0));
        exp_rx_q.push_back(r);
      end
    end
    exp_bus_q.push_back(mk_acc(1'b1, 8'h04, 32'hFFFF_FFFF));
    tx_allowed = tx_en && (len > 0);
    rx_allowed = rx_en && (len > 0);
    rx_stall   = stall;

    n = 0;
    while (!bus_if.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(bus_if.cmd_ready, "cmd_ready_idle", bus_if.cmd_ready, 1);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_sel   = sel;
    bus_if.cmd_len   = 16'(len);
    bus_if.cmd_tx_en = tx_en;
    bus_if.cmd_rx_en = rx_en;
    @(negedge clk);
    check(bus_if.busy && !bus_if.cmd_ready, "busy_after_accept",
          {bus_if.busy, bus_if.cmd_ready}, 2'b10);
    // Garbage command held valid while busy must be ignored.
    bus_if.cmd_sel   = $urandom;
    bus_if.cmd_len   = 16'($urandom);
    bus_if.cmd_tx_en = 1'($urandom);
    bus_if.cmd_rx_en = 1'($urandom);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1;
    bus_if.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    flush_all();
    reset = 1'b0;
  endtask

  task automatic finish_cmd(input int len, input int base);
    int n;
    n = 0;
    while (!bus_if.cmd_done && n < 400 + 200 * len) begin
      @(negedge clk);
      n++;
    end
    bus_if.cmd_valid = 1'b0;
    check(bus_if.cmd_done, "cmd_done_timeout", bus_if.cmd_done, 1);
    if (!bus_if.cmd_done) begin
      reset_dut();
      return;
    end
    @(negedge clk);
    check(!bus_if.busy && bus_if.cmd_ready, "idle_after_done",
          {bus_if.busy, bus_if.cmd_ready}, 2'b01);
    @(negedge clk);
    check(done_cnt == base + 1, "cmd_done_count", done_cnt, base + 1);
    check(exp_bus_q.size() == 0, "bus_accesses_left", exp_bus_q.size(), 0);
    check(exp_rx_q.size() == 0, "rx_bytes_left", exp_rx_q.size(), 0);
    check(tx_q.size() == 0, "tx_bytes_left", tx_q.size(), 0);
    tx_allowed = 0;
    rx_allowed = 0;
  endtask

  task automatic run_cmd(input logic [31:0] sel, input int len, input bit tx_en,
                         input bit rx_en, input bit echo, input int stall);
    int base;
    base = done_cnt;
    start_cmd(sel, len, tx_en, rx_en, echo, stall);
    finish_cmd(len, base);
  endtask

  initial begin
    int base;
    int n;
    reset = 1'b1;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_sel   = '0;
    bus_if.cmd_len   = '0;
    bus_if.cmd_tx_en = 1'b0;
    bus_if.cmd_rx_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check(!bus_if.spi_wr && !bus_if.spi_rd, "rst_strobes", {bus_if.spi_wr, bus_if.spi_rd}, 0);
    check(bus_if.spi_addr == 8'h0, "rst_addr", bus_if.spi_addr, 0);
    check(bus_if.spi_wdat == 32'h0, "rst_wdat", bus_if.spi_wdat, 0);
    check(!bus_if.tx_ready && !bus_if.rx_valid, "rst_streams",
          {bus_if.tx_ready, bus_if.rx_valid}, 0);
    check(bus_if.rx_data == 8'h0, "rst_rx_data", bus_if.rx_data, 0);
    check(!bus_if.cmd_done && !bus_if.busy, "rst_status",
          {bus_if.cmd_done, bus_if.busy}, 0);
    check(!bus_if.cmd_ready, "rst_cmd_ready_low", bus_if.cmd_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    check(bus_if.cmd_ready, "cmd_ready_after_reset", bus_if.cmd_ready, 1);

    // Two-byte echo burst to device 0.
    force_tx.push_back(8'hA5);
    force_tx.push_back(8'h3C);
    run_cmd(32'h1, 2, 1'b1, 1'b1, 1'b1, 0);

    // Zero-length command: select/deselect only.
    run_cmd(32'h0000_8421, 0, 1'b1, 1'b1, 1'b0, 0);

    // Fill-byte reads with fixed returned data.
    force_rd.push_back(8'h11);
    force_rd.push_back(8'h22);
    force_rd.push_back(8'h33);
    run_cmd(32'h4, 3, 1'b0, 1'b1, 1'b0, 0);

    // Consumer stalls 20 cycles on every received byte.
    run_cmd(32'h80, 2, 1'b1, 1'b1, 1'b0, 20);

    for (int i = 0; i < 25; i++) begin
      logic [31:0] sel;
      sel = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      run_cmd(sel, int'($urandom_range(0, 6)), 1'($urandom), 1'($urandom),
              1'b0, int'($urandom_range(0, 3)));
    end

    // Reset while a data write is outstanding.
    base = done_cnt;
    hold_xfer = 1;
    start_cmd(32'h2, 3, 1'b1, 1'b0, 1'b0, 0);
    n = 0;
    while (!(bus_if.spi_wr && bus_if.spi_addr == 8'h08) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(bus_if.spi_wr && bus_if.spi_addr == 8'h08, "reach_xfer",
          {bus_if.spi_wr, bus_if.spi_addr}, {1'b1, 8'h08});
    reset = 1'b1;
    bus_if.cmd_valid = 1'b0;
    @(negedge clk);
    check(!bus_if.spi_wr && !bus_if.busy, "abort_on_reset",
          {bus_if.spi_wr, bus_if.busy}, 0);
    check(!bus_if.cmd_ready, "cmd_ready_in_reset", bus_if.cmd_ready, 0);
    @(negedge clk);
    flush_all();
    reset = 1'b0;
    @(negedge clk);
    check(bus_if.cmd_ready && !bus_if.spi_wr && !bus_if.spi_rd, "idle_after_abort",
          {bus_if.cmd_ready, bus_if.spi_wr, bus_if.spi_rd}, 3'b100);
    check(done_cnt == base, "no_done_after_abort", done_cnt, base);
    run_cmd(32'hFFFF_FFFF, 2, 1'b1, 1'b1, 1'b0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_burst_seq.md
SPI_BURST_SEQ -- requirements
Module: spi_burst_seq

Interface
REQ-001 SHALL have parameter CS_LENGTH, default 32, chip-select vector width.
REQ-002 SHALL have parameter LEN_W, default 16, byte-count width.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports cmd_valid/cmd_ready  input/output  1  command handshake; a command is accepted on a cycle with both high.
REQ-006 SHALL have port cmd_sel  input  CS_LENGTH  one-hot-or-multi select mask; 1 = select that device.
REQ-007 SHALL have port cmd_len  input  LEN_W  number of bytes to transfer.
REQ-008 SHALL have port cmd_tx_en  input  1  1 = bytes from tx stream, 0 = send 0xFF without consuming tx.
REQ-009 SHALL have port cmd_rx_en  input  1  1 = return received bytes on rx stream, 0 = discard.
REQ-010 SHALL have ports tx_valid/tx_ready  input/output  1  and tx_data  input  8  byte stream in.
REQ-011 SHALL have ports rx_valid/rx_ready  output/input  1  and rx_data  output  8  byte stream out.
REQ-012 SHALL have ports spi_wr, spi_rd  output  1, spi_addr  output  8, spi_wdat  output  32  SPI-controller register bus requests.
REQ-013 SHALL have ports spi_rdat  input  32, spi_done  input  1  SPI-controller completion; data valid with done.
REQ-014 SHALL have ports busy  output  1  (command in progress) and cmd_done  output  1  (one-cycle completion pulse).

Function
REQ-015 Bus rule: spi_wr/spi_rd, spi_addr, spi_wdat SHALL be held constant from request start until the cycle spi_done is sampled high, and SHALL be low in the cycle following; never both high.
REQ-016 Bus rule: at least one cycle with spi_wr=spi_rd=0 SHALL separate consecutive accesses.
REQ-017 States SHALL be IDLE, CS_ON, GET_TX, XFER, READ, PUSH_RX, CS_OFF, FIN.
REQ-018 IDLE: cmd_ready=1; on acceptance latch sel, len, tx_en, rx_en into registers, load remaining count = cmd_len, go CS_ON.
REQ-019 CS_ON: write addr 0x04, wdat = zero-extended ~cmd_sel (active-low CS); on done go GET_TX if count>0, else CS_OFF.
REQ-020 GET_TX: if tx_en, tx_ready=1 and byte captured on tx_valid&tx_ready; if !tx_en byte = 0xFF immediately (0 cycles wait allowed, ≤1 cycle); then XFER.
REQ-021 XFER: write addr 0x08, wdat = {24'h0, byte}; on done go READ if rx_en, else decrement count and go GET_TX (count>0) or CS_OFF.
REQ-022 READ: read addr 0x08; on done capture spi_rdat[7:0], go PUSH_RX.
REQ-023 PUSH_RX: rx_valid=1, rx_data stable until rx_ready; on handshake decrement count, go GET_TX (count>0) or CS_OFF.
REQ-024 CS_OFF: write addr 0x04, wdat = all ones (CS_LENGTH bits, zero-extended); on done go FIN.
REQ-025 FIN: cmd_done=1 for exactly one cycle, go IDLE; busy=1 in all states except IDLE.
REQ-026 tx_ready SHALL be high only in GET_TX with tx_en; rx_valid only in PUSH_RX; cmd_ready only in IDLE.
REQ-027 Count SHALL be LEN_W bits, decrement-only, never wraps; cmd_len=0 performs CS_ON then CS_OFF with no byte traffic.
REQ-028 Command inputs SHALL be ignored outside IDLE; cmd_sel=0 SHALL still execute (no device selected).
REQ-029 spi_done high while no request is outstanding SHALL be ignored.

Reset
REQ-030 On reset: state IDLE, count 0, spi_wr=spi_rd=0, spi_addr=0, spi_wdat=0, tx_ready=0, rx_valid=0, rx_data=0, cmd_done=0, busy=0, cmd_ready=0 during reset cycle and 1 thereafter.
REQ-031 Reset mid-command SHALL abort with no further bus access; CS restoration is the controller's own reset.

Verification
REQ-032 cmd sel=0x1,len=2,tx_en=1,rx_en=1, tx 0xA5,0x3C, model echoes -> bus: wr 04/FFFFFFFE, wr 08/A5, rd 08, wr 08/3C, rd 08, wr 04/FFFFFFFF; rx 0xA5,0x3C; one cmd_done.
REQ-033 len=0 -> exactly two writes to 0x04 (~sel then all ones), cmd_done, no tx_ready/rx_valid.
REQ-034 tx_en=0,rx_en=1,len=3, model returns 0x11,0x22,0x33 -> wdat 0xFF thrice, rx 11,22,33, tx_ready never high.
REQ-035 rx_ready held low 20 cycles in PUSH_RX -> rx_data stable, no bus access, resumes on rx_ready.
REQ-036 spi_done delayed 0..10 cycles randomly -> REQ-015/016 hold every access; gap ≥1 cycle.
REQ-037 reset asserted during XFER -> next cycle spi_wr=0, busy=0; new command then runs normally.
